wb_pixel_master: RTL and testbench
==================================

// Module: wb_pixel_master
// PURPOSE
//  Wishbone initiator streaming 12-bit RGB444 pixels into the wb_pantalla display slave.
//  - Buffers a valid/ready pixel stream in a small FIFO.
//  - Runs a one-time init write sequence on start, then two Wishbone writes per pixel.
//  - Sits between the capture/pixel-generation path and the display slave on the shared bus.
// PARAMETERS
//  BASE_ADR       32'h0000_0000  byte address of the display slave register block
//  FIFO_DEPTH     16             pixel FIFO entries (power of two, >=2)
//  FRAME_PIXELS   19200          pixels per frame (160x120); sets frame_done
//  TIMEOUT_CYCLES 255            ack wait limit; used only with WB_PIXEL_TIMEOUT_EN
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  start       in   1   1-cycle pulse: run the init sequence, then stream pixels
//  busy        out  1   high from accepted start until reset/error
//  frame_done  out  1   1-cycle pulse when the ack of the last pixel's W_ENABLE write arrives
//  err         out  1   1-cycle pulse on ack timeout (timeout build only; otherwise tied 0)
//  pix_valid   in   1   source pixel valid
//  pix_ready   out  1   FIFO not full
//  pix_data    in   12  {R[3:0],G[3:0],B[3:0]}
//  wb_cyc_o    out  1   bus cycle
//  wb_stb_o    out  1   strobe (always equals wb_cyc_o)
//  wb_we_o     out  1   always 1 during a cycle (write-only master)
//  wb_adr_o    out  32  BASE_ADR + register offset
//  wb_sel_o    out  4   4'hF during a cycle
//  wb_dat_o    out  32  write data, zero-extended
//  wb_ack_i    in   1   slave acknowledge
// BEHAVIOUR
//  Reset values:
//  - cyc/stb/we = 0; adr/sel/dat = 0.
//  - busy/frame_done/err = 0; FIFO empty; pixel count 0; FSM in IDLE.
//  Push and pop:
//  - Push when pix_valid & pix_ready.
//  - pix_ready = !full. At full, no push even if a pop occurs in the same cycle.
//  - Pop occurs on the ack of a PIX write.
//  FSM: IDLE -> RST1 -> RST0 -> REN -> WEN1 -> WAITPIX -> PIX -> WEN -> WAITPIX ...
//  - IDLE: on start go to RST1 and set busy.
//  - RST1: writes 1 to offset 0xC.
//  - RST0: writes 0 to offset 0xC.
//  - REN: writes 1 to offset 0x8.
//  - WEN1: writes 1 to offset 0x4.
//  - WAITPIX: waits for FIFO non-empty.
//  - PIX: writes the FIFO head to offset 0x0.
//  - WEN: writes 1 to offset 0x4.
//  Write-state handshake:
//  - Each write state drives cyc/stb/we/sel/adr/dat and holds them stable until wb_ack_i is sampled high.
//  - The next cycle deasserts cyc/stb (1 idle cycle). Only then does the next state assert.
//  - Minimum 3 clk per write against a registered-ack slave; 6 clk per pixel.
//  - Ack outside a cycle is ignored.
//  Frame counting:
//  - 15-bit pixel counter increments on each WEN ack.
//  - When it reaches FRAME_PIXELS-1: frame_done pulses, the counter wraps to 0, streaming continues with no re-init.
//  Simultaneous events and reset:
//  - start while busy: ignored.
//  - Push and pop in the same cycle: count unchanged.
//  - Reset mid-cycle: bus deasserted at the next edge; FIFO flushed; pixel in flight lost.
// CONFIGURATION
//  WB_PIXEL_TIMEOUT_EN defined:
//  - 8-bit wait counter runs while cyc is high without ack.
//  - Reaching TIMEOUT_CYCLES drops cyc/stb, pulses err, flushes the FIFO, clears busy, returns to IDLE.
//  WB_PIXEL_TIMEOUT_EN undefined:
//  - Waits for ack indefinitely; err is constant 0.
// STRUCTURE
//  Package wb_pantalla_pkg:
//  - Register offsets REG_PIXEL=0x0, REG_WEN=0x4, REG_REN=0x8, REG_RST=0xC.
//  - PIX_W=12; FSM state enum.
//  Sub-module pix_fifo:
//  - Sync FIFO with WIDTH/DEPTH parameters and full/empty flags.
//  - Read data valid combinationally at head.
// TESTING
//  1. reset, start, ack 1 cycle after stb -> writes in order: 0xC=1, 0xC=0, 0x8=1, 0x4=1; busy=1; idle cycle between each.
//  2. push 12'hABC, ack after 1 cycle -> adr BASE+0 dat 32'h00000ABC, then adr BASE+4 dat 1; FIFO empty afterward.
//  3. push 17 pixels with ack held off (DEPTH=16) -> pix_ready=0 after 16 entries; order preserved on release.
//  4. FRAME_PIXELS=4, stream 5 pixels -> frame_done pulses exactly once on the 4th WEN ack; 5th pixel written, counter=1.
//  5. reset asserted while stb=1 awaiting ack -> cyc/stb=0 next edge, busy=0, pix_ready=1; new start re-runs init.
//  6. timeout build, TIMEOUT_CYCLES=8, no ack -> cyc high 8 cycles then 0, err 1-cycle pulse, FSM IDLE; non-timeout build: cyc held.

Source files
------------

// File: rtl/wb_pantalla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pantalla_pkg
// Description : Shared definitions for the wb_pantalla display slave and its
//               Wishbone pixel initiator: register map, pixel width, FSM
//               state encoding, and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pantalla_pkg;

  // Pixel format: {R[3:0], G[3:0], B[3:0]}
  localparam int PIX_W = 12;

  // Register byte offsets inside the display slave block
  localparam logic [31:0] REG_PIXEL = 32'h0000_0000;
  localparam logic [31:0] REG_WEN   = 32'h0000_0004;
  localparam logic [31:0] REG_REN   = 32'h0000_0008;
  localparam logic [31:0] REG_RST   = 32'h0000_000C;

  // Initiator FSM states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RST1    = 4'd1,
    ST_RST0    = 4'd2,
    ST_REN     = 4'd3,
    ST_WEN1    = 4'd4,
    ST_WAITPIX = 4'd5,
    ST_PIX     = 4'd6,
    ST_WEN     = 4'd7
  } state_t;

  // Register targeted by each write state
  function automatic logic [31:0] reg_offset(state_t s);
    case (s)
      ST_RST1, ST_RST0: reg_offset = REG_RST;
      ST_REN:           reg_offset = REG_REN;
      ST_WEN1, ST_WEN:  reg_offset = REG_WEN;
      default:          reg_offset = REG_PIXEL;
    endcase
  endfunction

  // Data written by each write state; the pixel is zero-extended to the bus
  function automatic logic [31:0] write_data(state_t s, logic [PIX_W-1:0] pix);
    case (s)
      ST_PIX:  write_data = {{(32-PIX_W){1'b0}}, pix};
      ST_RST0: write_data = 32'd0;
      default: write_data = 32'd1;
    endcase
  endfunction

  // State that follows a write once it has been acknowledged
  function automatic state_t write_successor(state_t s);
    case (s)
      ST_RST1: write_successor = ST_RST0;
      ST_RST0: write_successor = ST_REN;
      ST_REN:  write_successor = ST_WEN1;
      ST_PIX:  write_successor = ST_WEN;
      default: write_successor = ST_WAITPIX;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pixel_master_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pix_fifo
// Description : Synchronous pixel FIFO with full/empty flags. The head entry
//               is presented combinationally on rd_data. A push into a full
//               FIFO is dropped even if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo
  import wb_pantalla_pkg::*;
#(
  parameter int WIDTH = PIX_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_FULL);
  assign empty   = (r_count == '0);
  assign w_push  = wr_en & ~full & ~flush;
  assign w_pop   = rd_en & ~empty & ~flush;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/wb_pixel_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_pixel_master
// Description : Wishbone write-only initiator that streams RGB444 pixels into
//               the wb_pantalla display slave. On start it runs the init
//               sequence (RST=1, RST=0, REN=1, WEN=1), then issues a PIXEL
//               write followed by a WEN write for every buffered pixel.
//               Each write is held until ack and followed by one idle cycle.
// Options     : WB_PIXEL_TIMEOUT_EN - abort a bus cycle after TIMEOUT_CYCLES
//               without ack, pulse err, flush the FIFO and return to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pixel_master
  import wb_pantalla_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          FRAME_PIXELS   = 19200,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             err,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_ack_i
);

  localparam logic [14:0] c_LAST_PIX = 15'(FRAME_PIXELS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_cyc;
  logic             w_cyc_next;
  logic [14:0]      r_pix_cnt;
  logic [14:0]      w_pix_cnt_next;
  logic             r_frame_done;
  logic             w_frame_done_next;
  logic             w_timeout;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [PIX_W-1:0] w_head;

  // A pixel leaves the FIFO only once its PIXEL write has been acknowledged
  assign w_pop = r_cyc & wb_ack_i & (r_state == ST_PIX);

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (w_timeout),
    .wr_en   (pix_valid),
    .wr_data (pix_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign pix_ready  = ~w_full;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;

`ifdef WB_PIXEL_TIMEOUT_EN
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait;
  logic       r_err;

  // Count cycles spent in the current bus cycle without an ack
  always_ff @(posedge clk) begin
    if (reset || !r_cyc || wb_ack_i) r_wait <= '0;
    else                             r_wait <= r_wait + 8'd1;
  end

  assign w_timeout = r_cyc & ~wb_ack_i & (r_wait == c_WAIT_LAST);

  // Single-cycle error pulse following an aborted bus cycle
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_timeout;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State, bus-cycle flag, frame counter and frame pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cyc        <= 1'b0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cyc        <= w_cyc_next;
      r_pix_cnt    <= w_pix_cnt_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // Next-state logic: a write state first raises cyc, then waits for ack,
  // then hands over to its successor with cyc low for one idle cycle
  always_comb begin
    w_state_next      = r_state;
    w_cyc_next        = r_cyc;
    w_pix_cnt_next    = r_pix_cnt;
    w_frame_done_next = 1'b0;

    if (w_timeout) begin
      w_state_next = ST_IDLE;
      w_cyc_next   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next = ST_RST1;
            w_cyc_next   = 1'b1;
          end
        end
        ST_WAITPIX: begin
          // The gap cycle after WEN is spent here, so PIX may start at once
          if (!w_empty) begin
            w_state_next = ST_PIX;
            w_cyc_next   = 1'b1;
          end
        end
        default: begin
          if (!r_cyc) begin
            w_cyc_next = 1'b1;
          end else if (wb_ack_i) begin
            w_cyc_next   = 1'b0;
            w_state_next = write_successor(r_state);
            if (r_state == ST_WEN) begin
              if (r_pix_cnt == c_LAST_PIX) begin
                w_pix_cnt_next    = '0;
                w_frame_done_next = 1'b1;
              end else begin
                w_pix_cnt_next = r_pix_cnt + 15'd1;
              end
            end
          end
        end
      endcase
    end
  end

  // Bus drive: address/data/select are decoded from the held state while cyc is up
  always_comb begin
    wb_cyc_o = r_cyc;
    wb_stb_o = r_cyc;
    wb_we_o  = r_cyc;
    wb_sel_o = 4'h0;
    wb_adr_o = 32'd0;
    wb_dat_o = 32'd0;
    if (r_cyc) begin
      wb_sel_o = 4'hF;
      wb_adr_o = BASE_ADR + reg_offset(r_state);
      wb_dat_o = write_data(r_state, w_head);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_pixel_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_pixel_master
// Description : Self-checking bench for wb_pixel_master. A queue-based model
//               of the expected write stream, FIFO occupancy and frame
//               pulses is compared against the bus every cycle; a vector
//               table and hand sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pixel_master;
  import wb_pantalla_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_0100;
  localparam int          DEPTH = 16;
  localparam int          FP    = 4;
  localparam int          TO    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = '0;
  logic        wb_ack_i = 1'b0;
  logic        busy, frame_done, err, pix_ready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  always #5 clk = ~clk;

  wb_pixel_master #(
    .BASE_ADR       (BASE),
    .FIFO_DEPTH     (DEPTH),
    .FRAME_PIXELS   (FP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_i   (wb_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          kind;   // 0 init, 1 pixel, 2 pixel enable
  } wr_t;

  typedef struct {
    logic [11:0] pix;
    int          lat;
    logic [31:0] exp_dat;
  } vec_t;

  int  n_vec = 0;
  int  n_miss = 0;
  wr_t init_tab[4];
  vec_t tab[6];
  wr_t init_q[$];
  wr_t pix_q[$];
  int  occ = 0, pix_done = 0, fd_seen = 0, n_writes = 0, cyc_cnt = 0;
  bit  exp_busy = 0, exp_fd = 0, mon_en = 1;
  int  ack_lat = 1;
  bit  ack_hold = 0, stray_en = 0;
  bit  prev_cyc = 0, prev_done = 0;
  logic [31:0] prev_adr, prev_dat;
  logic [31:0] last_pix_adr = '0, last_pix_dat = '0, last_wen_adr = '0, last_wen_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update for the coming clock edge, using inputs/outputs stable now
  task automatic pre_edge();
    wr_t e;
    bit  done;
    if (reset) begin
      init_q.delete(); pix_q.delete();
      occ = 0; pix_done = 0; exp_busy = 0; exp_fd = 0;
      cyc_cnt = 0; prev_cyc = 0; prev_done = 0;
    end else begin
      done = wb_cyc_o && wb_ack_i;
      if (done) n_writes++;
      if (done && mon_en) begin
        e.kind = -1;
        if (init_q.size() > 0)     e = init_q.pop_front();
        else if (pix_q.size() > 0) e = pix_q.pop_front();
        else begin
          n_vec++; n_miss++;
          $display("FAIL unexpected write: adr %h dat %h", wb_adr_o, wb_dat_o);
        end
        if (e.kind >= 0) begin
          check("write adr", wb_adr_o, e.adr);
          check("write dat", wb_dat_o, e.dat);
          if (e.kind == 1) begin
            occ--; last_pix_adr = wb_adr_o; last_pix_dat = wb_dat_o;
          end
          if (e.kind == 2) begin
            pix_done++; last_wen_adr = wb_adr_o; last_wen_dat = wb_dat_o;
            if (pix_done % FP == 0) exp_fd = 1;
          end
        end
      end
      if (pix_valid && pix_ready) begin
        occ++;
        pix_q.push_back('{BASE + REG_PIXEL, {20'h0, pix_data}, 1});
        pix_q.push_back('{BASE + REG_WEN, 32'd1, 2});
      end
      if (start && !exp_busy) begin
        exp_busy = 1;
        for (int i = 0; i < 4; i++) init_q.push_back(init_tab[i]);
      end
      if (wb_cyc_o && !done) cyc_cnt++;
      else                   cyc_cnt = 0;
      prev_cyc  = wb_cyc_o;
      prev_done = done;
      prev_adr  = wb_adr_o;
      prev_dat  = wb_dat_o;
    end
  endtask

  // Slave response and per-cycle protocol checks after the edge
  task automatic post_edge();
    if (!wb_cyc_o) wb_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
    else           wb_ack_i = !ack_hold && (cyc_cnt >= ack_lat);
    if (frame_done) fd_seen++;
    if (mon_en) begin
      check("bus ctl", {26'h0, wb_stb_o, wb_we_o, wb_sel_o}, wb_cyc_o ? 32'h3F : 32'h0);
      if (prev_done) check("idle cycle after ack", wb_cyc_o, 1'b0);
      if (prev_cyc && !prev_done) begin
        check("cyc held until ack", wb_cyc_o, 1'b1);
        check("adr stable", wb_adr_o, prev_adr);
        check("dat stable", wb_dat_o, prev_dat);
      end
      check("busy", busy, exp_busy);
      check("frame_done", frame_done, exp_fd);
      check("err", err, 1'b0);
      check("pix_ready", pix_ready, occ < DEPTH);
    end
    exp_fd = 0;
  endtask

  task automatic step();
    pre_edge();
    @(posedge clk);
    @(negedge clk);
    post_edge();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic push_pixel(input logic [11:0] d, input int bound);
    bit acc = 0;
    int n = 0;
    pix_data = d; pix_valid = 1'b1;
    while (!acc && n < bound) begin
      acc = pix_ready;
      step(); n++;
    end
    pix_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_miss++;
      $display("FAIL push timeout: pixel %h not accepted in %0d cycles", d, bound);
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((init_q.size() > 0 || pix_q.size() > 0 || wb_cyc_o) && n < bound) begin
      step(); n++;
    end
    if (n >= bound) begin
      n_vec++; n_miss++;
      $display("FAIL drain timeout: %0d writes pending, cyc %b", init_q.size() + pix_q.size(), wb_cyc_o);
    end
  endtask

  initial begin
    int n, w0;
    init_tab[0] = '{BASE + REG_RST, 32'd1, 0};
    init_tab[1] = '{BASE + REG_RST, 32'd0, 0};
    init_tab[2] = '{BASE + REG_REN, 32'd1, 0};
    init_tab[3] = '{BASE + REG_WEN, 32'd1, 0};
    tab[0] = '{12'hABC, 1, 32'h0000_0ABC};
    tab[1] = '{12'h000, 2, 32'h0000_0000};
    tab[2] = '{12'hFFF, 3, 32'h0000_0FFF};
    tab[3] = '{12'h5A5, 1, 32'h0000_05A5};
    tab[4] = '{12'h123, 4, 32'h0000_0123};
    tab[5] = '{12'h800, 2, 32'h0000_0800};

    // Reset values
    do_reset();
    check("rst cyc", wb_cyc_o, 1'b0);
    check("rst stb", wb_stb_o, 1'b0);
    check("rst we", wb_we_o, 1'b0);
    check("rst adr", wb_adr_o, 32'h0);
    check("rst sel", wb_sel_o, 4'h0);
    check("rst dat", wb_dat_o, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst frame_done", frame_done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst pix_ready", pix_ready, 1'b1);

    // Init sequence, with a second start during init that must be ignored
    do_start();
    step(); step();
    do_start();
    drain(200);
    check("busy after init", busy, 1'b1);

    // Single-pixel vectors
    for (int i = 0; i < 6; i++) begin
      ack_lat = tab[i].lat;
      push_pixel(tab[i].pix, 50);
      drain(200);
      check("tab pix adr", last_pix_adr, BASE);
      check("tab pix dat", last_pix_dat, tab[i].exp_dat);
      check("tab wen adr", last_wen_adr, BASE + 32'h4);
      check("tab wen dat", last_wen_dat, 32'd1);
      step(); step(); step();
      check("tab fifo empty", wb_cyc_o, 1'b0);
    end
    ack_lat = 1;

    // FIFO fill to full while idle, then release and check order
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_pixel(12'($urandom), 5);
    check("fifo full ready", pix_ready, 1'b0);
    pix_data = 12'h777; pix_valid = 1'b1;
    step(); step(); step();
    check("full no push", pix_ready, 1'b0);
    pix_valid = 1'b0;
    do_start();
    push_pixel(12'h777, 200);
    drain(1000);

    // Frame counting: one pulse for 5 pixels, second pulse on the 8th
    do_reset();
    fd_seen = 0;
    do_start();
    drain(200);
    for (int i = 0; i < 5; i++) begin
      ack_lat = $urandom_range(1, 3);
      push_pixel(12'($urandom), 50);
    end
    drain(500);
    check("frame pulses after 5 px", fd_seen, 1);
    for (int i = 0; i < 3; i++) push_pixel(12'($urandom), 50);
    drain(500);
    check("frame pulses after 8 px", fd_seen, 2);
    ack_lat = 1;

    // Reset while a PIXEL write waits for ack
    ack_hold = 1;
    push_pixel(12'h3C3, 50);
    n = 0;
    while (!wb_cyc_o && n < 20) begin step(); n++; end
    check("cyc up before reset", wb_cyc_o, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid reset cyc", wb_cyc_o, 1'b0);
    check("mid reset stb", wb_stb_o, 1'b0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset ready", pix_ready, 1'b1);
    ack_hold = 0;
    w0 = n_writes;
    do_start();
    drain(200);
    check("re-init writes", n_writes - w0, 4);

    // Ack withheld: timeout build aborts, default build holds the cycle
    do_reset();
    ack_hold = 1;
    do_start();
`ifdef WB_PIXEL_TIMEOUT_EN
    mon_en = 0;
    n = 0;
    while (wb_cyc_o && n < 50) begin step(); n++; end
    check("timeout cyc cycles", n, TO);
    check("timeout err pulse", err, 1'b1);
    check("timeout busy", busy, 1'b0);
    step();
    check("timeout err cleared", err, 1'b0);
    ack_hold = 0;
    do_reset();
    mon_en = 1;
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("cyc held w/o ack", wb_cyc_o, 1'b1);
    end
    ack_hold = 0;
    drain(200);
`endif

    // Randomized streaming with stray acks outside bus cycles
    do_reset();
    stray_en = 1;
    do_start();
    for (int i = 0; i < 400; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 12'($urandom);
      ack_lat   = $urandom_range(1, 4);
      step();
    end
    pix_valid = 1'b0;
    drain(3000);
    stray_en = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
